// File: rtl/serial_adder_if.sv
// serial_adder_if
//   Operand and result handshakes for the bit-serial adder.
//   master: operand producer / result consumer side (drives operands, out_ready).
//   slave : the adder (drives in_ready, out_valid, sum, cout).
//   Ports: in_valid/in_ready/a/b/cin[/sub], out_valid/out_ready/sum/cout.
//   Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub signal.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full-adder stage plus a carry flop, LSB first.
//   Accepts {a, b, cin} on the operand handshake, returns {cout, sum} =
//   a + b + cin after WIDTH RUN cycles on the result handshake.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - serial_adder_if.slave (operand and result handshakes)
//     busy  - high while in RUN or DONE
//   Parameter WIDTH: operand/sum width, 2..32.
//   Optional feature macro: SERIAL_ADDER_SUB_EN enables subtract mode
//   (b loaded inverted, carry loaded with 1, cin ignored).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_adder_if.slave        bus,
    output logic                 busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             last_bit;
    logic             s_bit;
    logic             c_next;
    logic             sub_op;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_op = bus.sub;
`else
    assign sub_op = 1'b0;
`endif

    // Subtraction is a + ~b + 1; the forced carry replaces cin.
    assign b_load = sub_op ? ~bus.b : bus.b;
    assign c_load = sub_op ? 1'b1   : bus.cin;

    assign load     = (state_q == IDLE) && bus.in_valid;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

    // Handshake outputs are pure state decodes: no combinational path
    // from in_valid or out_ready.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign bus.sum       = sum_r;
    assign bus.cout      = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_bit)      state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_sh  <= bus.a;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            // Result bits enter at the MSB so bit 0 lands at sum[0] after WIDTH shifts.
            sum_r <= {s_bit, sum_r[WIDTH-1:1]};
            carry <= c_next;
            cnt   <= cnt + CW'(1);
        end
    end
endmodule
